// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the fetch FSM state type.
package cpu_pkg;

  localparam int ADDR_W      = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;
  localparam int FETCH_DEPTH = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Sync FIFO with flush and count; head comes straight from registers, a push is visible next cycle.
// Pushes into a full FIFO are ignored; the owner keeps occupancy within DEPTH.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push_vld,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop_rdy,
  output logic                   o_pop_vld,
  output logic [WIDTH-1:0]       o_pop_dat,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push    = i_push_vld && (r_count != CNT_W'(DEPTH));
  assign w_pop     = i_pop_rdy && (r_count != '0);
  assign o_pop_vld = (r_count != '0);
  // Idle head reads as zero so downstream never sees stale words.
  assign o_pop_dat = o_pop_vld ? r_mem[r_rd_ptr] : '0;
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: owns the PC, keeps at most DEPTH words in flight or buffered, drops wrong-path returns.
// A response at cycle N reaches decode at N+1 earliest; a stalled decode stops new requests once DEPTH is used.
module instruction_fetch #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
  parameter int                DEPTH    = cpu_pkg::FETCH_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [ADDR_W-1:0]  if_address,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  branch_address
);

  import cpu_pkg::*;

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WORD_W = INSTR_W + ADDR_W;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  w_out_nxt;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [CNT_W-1:0]  w_drop_nxt;
  logic [CNT_W-1:0]  w_fifo_cnt;
  logic [CNT_W-1:0]  w_tag_cnt_unused;
  logic [CNT_W:0]    w_in_use;
  logic              w_req_acc;
  logic              w_rsp_keep;
  logic              w_tag_vld;
  logic              w_fifo_vld;
  logic [ADDR_W-1:0] w_tag_addr;
  logic [ADDR_W-1:0] w_target;
  logic [WORD_W-1:0] w_fifo_dat;

  assign w_in_use       = {1'b0, r_outstanding} + {1'b0, w_fifo_cnt};
  assign imem_req_valid = (r_state != ST_START) && (w_in_use < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_acc      = imem_req_valid && imem_req_ready;
  assign w_target       = branch_address & ~ADDR_W'(INSTR_BYTES - 1);
  assign w_out_nxt      = r_outstanding + CNT_W'(w_req_acc) - CNT_W'(imem_rsp_valid);

  // A response in the redirect cycle belongs to the old path even when drop_cnt is zero.
  assign w_rsp_keep = imem_rsp_valid && (r_drop_cnt == '0) && !pc_src && w_tag_vld;

  always_comb begin
    w_drop_nxt = r_drop_cnt;
    if (pc_src) begin
      w_drop_nxt = w_out_nxt;
    end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
      w_drop_nxt = r_drop_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_START: w_state_nxt = ST_RUN;
      ST_RUN:   if (pc_src && (w_out_nxt != '0)) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_drop_nxt == '0) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_START;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      r_drop_cnt    <= w_drop_nxt;
      if (pc_src) begin
        r_pc <= w_target;
      end else if (w_req_acc) begin
        r_pc <= r_pc + ADDR_W'(INSTR_BYTES);
      end
    end
  end

  // Address tags of live (not-to-be-dropped) requests, consumed in response order.
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (pc_src),
    .i_push_vld (w_req_acc && !pc_src),
    .i_push_dat (r_pc),
    .i_pop_rdy  (w_rsp_keep),
    .o_pop_vld  (w_tag_vld),
    .o_pop_dat  (w_tag_addr),
    .o_count    (w_tag_cnt_unused)
  );

  fetch_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_word_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (pc_src),
    .i_push_vld (w_rsp_keep),
    .i_push_dat ({imem_rsp_data, w_tag_addr}),
    .i_pop_rdy  (if_ready),
    .o_pop_vld  (w_fifo_vld),
    .o_pop_dat  (w_fifo_dat),
    .o_count    (w_fifo_cnt)
  );

  assign if_valid                     = w_fifo_vld;
  assign {if_instruction, if_address} = w_fifo_dat;

endmodule
